branch_resolve_unit: RTL

Resolution-side companion to the fetch-stage branch predictor table. It holds predictions issued at fetch for branch instructions (opcode 4), retires them in order as the EX stage resolves each branch, and raises a one-cycle flush with a corrected PC on misprediction. It also queues training records (PC, actual outcome, actual target) and hands them back to the predictor table over a valid/ready handshake. It sits between the IF/ID prediction path and the EX-stage branch comparator.

---
 rtl/branch_resolve_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: in-order in-flight prediction FIFO, mispredict flush/redirect, and a training update queue.
// Optional BRU_STATS_EN adds wrapping resolution and mispredict counters on br_count/mis_count.
module branch_resolve_unit #(
  parameter int PC_W     = 13,
  parameter int DEPTH    = 4,
  parameter int UQ_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pred_valid,
  input  logic [PC_W-1:0]          pred_pc,
  input  logic                     pred_taken,
  input  logic [PC_W-1:0]          pred_target,
  input  logic                     res_valid,
  input  logic                     res_taken,
  input  logic [PC_W-1:0]          res_target,
  output logic                     flush,
  output logic [PC_W-1:0]          redirect_pc,
  output logic                     upd_valid,
  input  logic                     upd_ready,
  output logic [PC_W-1:0]          upd_pc,
  output logic                     upd_taken,
  output logic [PC_W-1:0]          upd_target,
  output logic [$clog2(DEPTH):0]   inflight_count,
  output logic                     err,
  output logic                     upd_drop,
  output logic [15:0]              br_count,
  output logic [15:0]              mis_count
);
  // Handshake: a training record transfers on any posedge where upd_valid && upd_ready;
  // until then the record on upd_pc/upd_taken/upd_target is held stable.
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int UPTR_W = $clog2(UQ_DEPTH);
  localparam int UCNT_W = $clog2(UQ_DEPTH) + 1;
  localparam logic [CNT_W-1:0]  IF_FULL = CNT_W'(DEPTH);
  localparam logic [UCNT_W-1:0] UQ_FULL = UCNT_W'(UQ_DEPTH);

  logic [PC_W-1:0]   if_pc  [DEPTH];
  logic [PC_W-1:0]   if_tgt [DEPTH];
  logic [DEPTH-1:0]  if_taken;
  logic [PTR_W-1:0]  if_rd, if_wr;

  logic [PC_W-1:0]    uq_pc  [UQ_DEPTH];
  logic [PC_W-1:0]    uq_tgt [UQ_DEPTH];
  logic [UQ_DEPTH-1:0] uq_taken;
  logic [UPTR_W-1:0]  uq_rd, uq_wr;
  logic [UCNT_W-1:0]  uq_cnt;

  logic            pop, push, mispredict, bad_res, bad_push;
  logic            uq_pop, uq_write, uq_lost;
  logic [PC_W-1:0] head_pc, head_tgt;
  logic            head_taken;

  always_comb begin
    head_pc    = if_pc[if_rd];
    head_tgt   = if_tgt[if_rd];
    head_taken = if_taken[if_rd];
    pop        = res_valid && (inflight_count != '0);
    bad_res    = res_valid && (inflight_count == '0);
    mispredict = pop && ((head_taken != res_taken) || (head_taken && (head_tgt != res_target)));
    bad_push   = pred_valid && (inflight_count == IF_FULL) && !pop;
    // A flush also squashes the same-cycle push, so that push is neither stored nor an error.
    push       = pred_valid && !mispredict && !bad_push;
    uq_pop     = (uq_cnt != '0) && upd_ready;
    uq_write   = pop && ((uq_cnt != UQ_FULL) || uq_pop);
    uq_lost    = pop && (uq_cnt == UQ_FULL) && !uq_pop;
  end

  assign upd_valid  = (uq_cnt != '0);
  assign upd_pc     = uq_pc[uq_rd];
  assign upd_taken  = uq_taken[uq_rd];
  assign upd_target = uq_tgt[uq_rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      flush          <= 1'b0;
      redirect_pc    <= '0;
      err            <= 1'b0;
      upd_drop       <= 1'b0;
      if_rd          <= '0;
      if_wr          <= '0;
      inflight_count <= '0;
      uq_rd          <= '0;
      uq_wr          <= '0;
      uq_cnt         <= '0;
      uq_taken       <= '0;
      for (int i = 0; i < UQ_DEPTH; i++) begin
        uq_pc[i]  <= '0;
        uq_tgt[i] <= '0;
      end
    end else begin
      flush    <= mispredict;
      upd_drop <= uq_lost;
      err      <= err | bad_res | bad_push;
      if (mispredict)
        redirect_pc <= res_taken ? res_target : head_pc + PC_W'(1);

      if (mispredict) begin
        if_rd          <= '0;
        if_wr          <= '0;
        inflight_count <= '0;
      end else begin
        if (push) begin
          if_pc[if_wr]    <= pred_pc;
          if_tgt[if_wr]   <= pred_target;
          if_taken[if_wr] <= pred_taken;
          if_wr           <= if_wr + PTR_W'(1);
        end
        if (pop)
          if_rd <= if_rd + PTR_W'(1);
        inflight_count <= inflight_count + CNT_W'(push) - CNT_W'(pop);
      end

      if (uq_write) begin
        uq_pc[uq_wr]    <= head_pc;
        uq_taken[uq_wr] <= res_taken;
        uq_tgt[uq_wr]   <= res_target;
        uq_wr           <= uq_wr + UPTR_W'(1);
      end
      if (uq_pop)
        uq_rd <= uq_rd + UPTR_W'(1);
      uq_cnt <= uq_cnt + UCNT_W'(uq_write) - UCNT_W'(uq_pop);
    end
  end

`ifdef BRU_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      br_count  <= '0;
      mis_count <= '0;
    end else begin
      if (pop)
        br_count <= br_count + 16'd1;
      if (mispredict)
        mis_count <= mis_count + 16'd1;
    end
  end
`else
  assign br_count  = 16'd0;
  assign mis_count = 16'd0;
`endif

endmodule
